// File: rtl/knockback_profile_ctrl_pkg.sv
// Shared types and default constants for the knockback profile controller.
package knockback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_COOLDOWN
  } kb_state_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_NUM_STEPS   = 3;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_V0          = 7;
  localparam int DEF_DV          = 2;
  localparam int DEF_VEL_W       = 10;
  localparam int DEF_COOLDOWN    = 0;
  localparam int DEF_RETRIGGER   = 0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knockback_profile_ctrl_if.sv
// Hit request / velocity bundle between the game logic and the controller.
interface knockback_profile_ctrl_if
  import knockback_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int VEL_W  = DEF_VEL_W
);

  logic [NUM_CH-1:0]       Punch;
  logic [NUM_CH-1:0]       Dir;
  logic [NUM_CH*VEL_W-1:0] Ball_X_Motion;
  logic [NUM_CH-1:0]       Busy;
  logic [NUM_CH-1:0]       Done;

  modport master (
    output Punch,
    output Dir,
    input  Ball_X_Motion,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Punch,
    input  Dir,
    output Ball_X_Motion,
    output Busy,
    output Done
  );

endinterface

// File: rtl/knockback_profile_ctrl_chan.sv
// One knockback channel: IDLE -> ACTIVE (stepped decaying velocity) -> optional COOLDOWN.
module knockback_chan
  import knockback_pkg::*;
#(
  parameter int NUM_STEPS   = DEF_NUM_STEPS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int V0          = DEF_V0,
  parameter int DV          = DEF_DV,
  parameter int VEL_W       = DEF_VEL_W,
  parameter int COOLDOWN    = DEF_COOLDOWN,
  parameter int RETRIGGER   = DEF_RETRIGGER
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    punch_i,
  input  logic                    dir_i,
  output logic signed [VEL_W-1:0] vel_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int STEP_W = cnt_w(NUM_STEPS);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int COOL_W = cnt_w(COOLDOWN);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [31:0]       V0_U      = 32'(V0);
  localparam logic [31:0]       DV_U      = 32'(DV);

  kb_state_e         state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              dir_q, dir_d;
  logic [31:0]       decrAmt;
  logic [VEL_W-1:0]  mag;

  // State and counters; reset aborts any profile in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      hold_q  <= '0;
      cool_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      cool_q  <= cool_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state sequencing and the completion pulse on the last held step.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    cool_d  = cool_q;
    dir_d   = dir_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (punch_i) begin
          state_d = ST_ACTIVE;
          step_d  = '0;
          hold_d  = '0;
          dir_d   = dir_i;
        end
      end
      ST_ACTIVE: begin
        if ((RETRIGGER != 0) && punch_i) begin
          step_d = '0;
          hold_d = '0;
          dir_d  = dir_i;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (step_q == STEP_LAST) begin
            done_o = 1'b1;
            step_d = '0;
            if (COOLDOWN > 0) begin
              state_d = ST_COOLDOWN;
              cool_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cool_q == COOL_LAST) begin
          state_d = ST_IDLE;
          cool_d  = '0;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Velocity comes purely from registered state: saturating decay, signed by latched dir.
  always_comb begin
    decrAmt = {{(32-STEP_W){1'b0}}, step_q} * DV_U;
    mag     = '0;
    vel_o   = '0;
    busy_o  = (state_q != ST_IDLE);
    if (decrAmt < V0_U) begin
      mag = VEL_W'(V0_U - decrAmt);
    end
    if (state_q == ST_ACTIVE) begin
      vel_o = dir_q ? -mag : mag;
    end
  end

endmodule

// File: rtl/knockback_profile_ctrl.sv
// Top level: NUM_CH independent knockback channels packed onto one bus.
module knockback_profile_ctrl
  import knockback_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int NUM_STEPS   = DEF_NUM_STEPS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int V0          = DEF_V0,
  parameter int DV          = DEF_DV,
  parameter int VEL_W       = DEF_VEL_W,
  parameter int COOLDOWN    = DEF_COOLDOWN,
  parameter int RETRIGGER   = DEF_RETRIGGER
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  knockback_profile_ctrl_if.slave  bus
);

  if ((V0 >= 2**(VEL_W-1)) || (NUM_STEPS < 1) || (HOLD_CYCLES < 1)) begin : g_bad_params
    $error("knockback_profile_ctrl: V0 must fit signed VEL_W, NUM_STEPS and HOLD_CYCLES must be >= 1");
  end

  logic [NUM_CH*VEL_W-1:0] motionBus;
  logic [NUM_CH-1:0]       busyVec;
  logic [NUM_CH-1:0]       doneVec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    knockback_chan #(
      .NUM_STEPS   (NUM_STEPS),
      .HOLD_CYCLES (HOLD_CYCLES),
      .V0          (V0),
      .DV          (DV),
      .VEL_W       (VEL_W),
      .COOLDOWN    (COOLDOWN),
      .RETRIGGER   (RETRIGGER)
    ) u_chan (
      .clk_i   (clk),
      .rst_ni  (Reset_n),
      .punch_i (bus.Punch[i]),
      .dir_i   (bus.Dir[i]),
      .vel_o   (motionBus[i*VEL_W +: VEL_W]),
      .busy_o  (busyVec[i]),
      .done_o  (doneVec[i])
    );
  end

  assign bus.Ball_X_Motion = motionBus;
  assign bus.Busy          = busyVec;
  assign bus.Done          = doneVec;

endmodule

// File: tb/tb_knockback_profile_ctrl.sv
// Scoreboard bench for knockback_profile_ctrl across four parameter sets.
module tb_knockback_profile_ctrl;
  import knockback_pkg::*;

  localparam int NCH = DEF_NUM_CH;
  localparam int VW  = DEF_VEL_W;

  typedef struct packed {
    logic [NCH*VW-1:0] motion;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
  } obs_t;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   profTbl [6] = '{7, 7, 5, 5, 3, 3};
  int   satTbl [10] = '{4, 4, 2, 2, 0, 0, 0, 0, 0, 0};

  obs_t qA[$];
  obs_t qR[$];
  obs_t qS[$];
  obs_t qC[$];

  knockback_profile_ctrl_if #(.NUM_CH(NCH), .VEL_W(VW)) ifA ();
  knockback_profile_ctrl_if #(.NUM_CH(NCH), .VEL_W(VW)) ifR ();
  knockback_profile_ctrl_if #(.NUM_CH(NCH), .VEL_W(VW)) ifS ();
  knockback_profile_ctrl_if #(.NUM_CH(NCH), .VEL_W(VW)) ifC ();

  knockback_profile_ctrl dutA (.clk(clk), .Reset_n(Reset_n), .bus(ifA));
  knockback_profile_ctrl #(.RETRIGGER(1)) dutR (.clk(clk), .Reset_n(Reset_n), .bus(ifR));
  knockback_profile_ctrl #(.NUM_STEPS(5), .V0(4), .DV(2)) dutS (.clk(clk), .Reset_n(Reset_n), .bus(ifS));
  knockback_profile_ctrl #(.COOLDOWN(3)) dutC (.clk(clk), .Reset_n(Reset_n), .bus(ifC));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic obs_t mk(int v0, int v1, logic b0, logic b1, logic d0, logic d1);
    obs_t o;
    o.motion = {VW'(v1), VW'(v0)};
    o.busy   = {b1, b0};
    o.done   = {d1, d0};
    return o;
  endfunction

  function automatic obs_t profStep(int i);
    return mk(profTbl[i], 0, 1'b1, 1'b0, (i == 5), 1'b0);
  endfunction

  function automatic obs_t idleObs();
    return mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ifA.Punch = '0; ifA.Dir = '0;
    ifR.Punch = '0; ifR.Dir = '0;
    ifS.Punch = '0; ifS.Dir = '0;
    ifC.Punch = '0; ifC.Dir = '0;
  endtask

  task automatic reset_all();
    Reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    Reset_n = 1'b0;
    drive_idle();
    #1;
    got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
    checks++;
    if (got !== idleObs()) begin errors++; $display("[TB] FAIL reset_a got=%h exp=%h", got, idleObs()); end
    got = {ifR.Ball_X_Motion, ifR.Busy, ifR.Done};
    checks++;
    if (got !== idleObs()) begin errors++; $display("[TB] FAIL reset_r got=%h exp=%h", got, idleObs()); end
    got = {ifS.Ball_X_Motion, ifS.Busy, ifS.Done};
    checks++;
    if (got !== idleObs()) begin errors++; $display("[TB] FAIL reset_s got=%h exp=%h", got, idleObs()); end
    got = {ifC.Ball_X_Motion, ifC.Busy, ifC.Done};
    checks++;
    if (got !== idleObs()) begin errors++; $display("[TB] FAIL reset_c got=%h exp=%h", got, idleObs()); end
    repeat (2) @(posedge clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_single_pos();
    obs_t got, exp;
    int n = 0;
    reset_all();
    for (int i = 0; i < 6; i++) qA.push_back(profStep(i));
    qA.push_back(idleObs());
    qA.push_back(idleObs());
    ifA.Dir = 2'b00;
    ifA.Punch = 2'b01;
    while (qA.size() > 0) begin
      cycle();
      ifA.Punch = '0;
      n++;
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL single_pos cyc%0d got=%h exp=%h", n, got, exp); end
    end
  endtask

  task automatic test_single_neg();
    obs_t got, exp;
    int n = 0;
    reset_all();
    for (int i = 0; i < 6; i++) qA.push_back(mk(0, -profTbl[i], 1'b0, 1'b1, 1'b0, (i == 5)));
    qA.push_back(idleObs());
    ifA.Dir = 2'b10;
    ifA.Punch = 2'b10;
    while (qA.size() > 0) begin
      cycle();
      ifA.Punch = '0;
      n++;
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL single_neg cyc%0d got=%h exp=%h", n, got, exp); end
    end
  endtask

  task automatic test_simultaneous();
    obs_t got, exp;
    int n = 0;
    reset_all();
    for (int i = 0; i < 6; i++) qA.push_back(mk(-profTbl[i], profTbl[i], 1'b1, 1'b1, (i == 5), (i == 5)));
    qA.push_back(idleObs());
    ifA.Dir = 2'b01;
    ifA.Punch = 2'b11;
    while (qA.size() > 0) begin
      cycle();
      ifA.Punch = '0;
      n++;
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL simultaneous cyc%0d got=%h exp=%h", n, got, exp); end
    end
  endtask

  task automatic test_saturation();
    obs_t got, exp;
    int n = 0;
    reset_all();
    for (int i = 0; i < 10; i++) qS.push_back(mk(satTbl[i], 0, 1'b1, 1'b0, (i == 9), 1'b0));
    qS.push_back(idleObs());
    ifS.Dir = 2'b00;
    ifS.Punch = 2'b01;
    while (qS.size() > 0) begin
      cycle();
      ifS.Punch = '0;
      n++;
      exp = qS.pop_front();
      got = {ifS.Ball_X_Motion, ifS.Busy, ifS.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL saturation cyc%0d got=%h exp=%h", n, got, exp); end
    end
  endtask

  task automatic test_retrigger();
    obs_t got, exp;
    reset_all();
    for (int i = 0; i < 4; i++) qR.push_back(mk(profTbl[i], 0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) qR.push_back(profStep(i));
    qR.push_back(idleObs());
    for (int i = 0; i < 6; i++) qA.push_back(profStep(i));
    for (int i = 0; i < 5; i++) qA.push_back(idleObs());
    ifR.Punch = 2'b01;
    ifA.Punch = 2'b01;
    for (int n = 1; n <= 11; n++) begin
      cycle();
      exp = qR.pop_front();
      got = {ifR.Ball_X_Motion, ifR.Busy, ifR.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL retrig_on cyc%0d got=%h exp=%h", n, got, exp); end
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL retrig_off cyc%0d got=%h exp=%h", n, got, exp); end
      ifR.Punch = (n == 4) ? 2'b01 : 2'b00;
      ifA.Punch = (n == 4) ? 2'b01 : 2'b00;
    end
  endtask

  task automatic test_cooldown();
    obs_t got, exp;
    reset_all();
    for (int i = 0; i < 6; i++) qC.push_back(profStep(i));
    for (int i = 0; i < 3; i++) qC.push_back(mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    qC.push_back(idleObs());
    for (int i = 0; i < 6; i++) qC.push_back(profStep(i));
    for (int i = 0; i < 6; i++) qA.push_back(profStep(i));
    qA.push_back(idleObs());
    for (int i = 0; i < 6; i++) qA.push_back(profStep(i));
    qA.push_back(idleObs());
    qA.push_back(profStep(0));
    qA.push_back(profStep(1));
    ifC.Punch = 2'b01;
    ifA.Punch = 2'b01;
    for (int n = 1; n <= 16; n++) begin
      cycle();
      exp = qC.pop_front();
      got = {ifC.Ball_X_Motion, ifC.Busy, ifC.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL cooldown cyc%0d got=%h exp=%h", n, got, exp); end
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL held_punch cyc%0d got=%h exp=%h", n, got, exp); end
    end
    ifC.Punch = '0;
    ifA.Punch = '0;
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    reset_all();
    for (int i = 0; i < 3; i++) qA.push_back(profStep(i));
    ifA.Punch = 2'b01;
    for (int n = 1; n <= 3; n++) begin
      cycle();
      ifA.Punch = '0;
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL pre_abort cyc%0d got=%h exp=%h", n, got, exp); end
    end
    qA.push_back(idleObs());
    Reset_n = 1'b0;
    #1;
    exp = qA.pop_front();
    got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL async_abort got=%h exp=%h", got, exp); end
    qA.push_back(idleObs());
    cycle();
    exp = qA.pop_front();
    got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL held_reset got=%h exp=%h", got, exp); end
    Reset_n = 1'b1;
    qA.push_back(profStep(0));
    qA.push_back(profStep(1));
    qA.push_back(profStep(2));
    ifA.Punch = 2'b01;
    for (int n = 1; n <= 3; n++) begin
      cycle();
      ifA.Punch = '0;
      exp = qA.pop_front();
      got = {ifA.Ball_X_Motion, ifA.Busy, ifA.Done};
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL post_release cyc%0d got=%h exp=%h", n, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pos();
    test_single_neg();
    test_simultaneous();
    test_saturation();
    test_retrigger();
    test_cooldown();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
